// File: rtl/pc_flag_unit.sv
// pc_flag_unit: program counter, branch resolution and compare flags for the
// 9-bit processor. Sequences start/halt and counts RUN cycles (saturating).
module pc_flag_unit #(
  parameter int unsigned PCW      = 10,
  parameter int unsigned DW       = 8,
  parameter int unsigned PROG_LEN = 1023
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           Start,
  input  logic           Branch,
  input  logic           Jump,
  input  logic           Beq,
  input  logic           Bne,
  input  logic           Bl,
  input  logic           Bg,
  input  logic           Cmpfl,
  input  logic           CmpWr,
  input  logic [DW-1:0]  CmpA,
  input  logic [DW-1:0]  CmpB,
  input  logic [PCW-1:0] BrTarget,
  output logic [PCW-1:0] PC,
  output logic           Done,
  output logic           BrTaken,
  output logic           FlagEq,
  output logic           FlagLt,
  output logic           FlagGt,
  output logic [15:0]    CycleCnt
);

  localparam int unsigned CNTW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t         state;
  logic           take_c;
  logic           cond_c;
  logic [PCW-1:0] next_pc_c;
  logic           halt_c;
  logic [CNTW-1:0] cnt_inc_c;

  // Branch decision uses the flags held before this edge; next PC and halt check
  always_comb begin
    cond_c    = (Beq & FlagEq) | (Bne & ~FlagEq) | (Bl & FlagLt) | (Bg & FlagGt);
    take_c    = Branch & (Jump | (Cmpfl & cond_c));
    next_pc_c = take_c ? BrTarget : PC + PCW'(1);
    halt_c    = 32'(next_pc_c) >= PROG_LEN;
    cnt_inc_c = (CycleCnt == {CNTW{1'b1}}) ? CycleCnt : CycleCnt + CNTW'(1);
  end

  // Run/halt sequencer with all outputs registered
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      PC       <= '0;
      Done     <= 1'b0;
      BrTaken  <= 1'b0;
      FlagEq   <= 1'b0;
      FlagLt   <= 1'b0;
      FlagGt   <= 1'b0;
      CycleCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          PC      <= '0;
          Done    <= 1'b0;
          BrTaken <= 1'b0;
          if (Start) state <= RUN;
        end
        RUN: begin
          BrTaken  <= take_c;
          CycleCnt <= cnt_inc_c;
          if (CmpWr) begin
            FlagEq <= (CmpA == CmpB);
            FlagLt <= (CmpA <  CmpB);
            FlagGt <= (CmpA >  CmpB);
          end
          if (halt_c) begin
            state <= HALT;
            Done  <= 1'b1;
          end else begin
            PC <= next_pc_c;
          end
        end
        HALT: begin
          BrTaken <= 1'b0;
          if (Start) begin
            state    <= RUN;
            PC       <= '0;
            CycleCnt <= '0;
            FlagEq   <= 1'b0;
            FlagLt   <= 1'b0;
            FlagGt   <= 1'b0;
            Done     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_flag_unit.sv
// Directed bench for pc_flag_unit: one instance with the default program
// length and one with PROG_LEN=8 for the halt scenarios.
module tb_pc_flag_unit;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic        Branch, Jump, Beq, Bne, Bl, Bg, Cmpfl, CmpWr;
  logic [7:0]  CmpA, CmpB;
  logic [9:0]  BrTarget;

  logic [9:0]  pc, pc8;
  logic        done, done8, brt, brt8;
  logic        feq, flt, fgt, feq8, flt8, fgt8;
  logic [15:0] cnt, cnt8;

  int total = 0;
  int bad   = 0;

  pc_flag_unit #(.PCW(10), .DW(8), .PROG_LEN(1023)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
    .Branch(Branch), .Jump(Jump), .Beq(Beq), .Bne(Bne), .Bl(Bl), .Bg(Bg),
    .Cmpfl(Cmpfl), .CmpWr(CmpWr), .CmpA(CmpA), .CmpB(CmpB), .BrTarget(BrTarget),
    .PC(pc), .Done(done), .BrTaken(brt), .FlagEq(feq), .FlagLt(flt), .FlagGt(fgt),
    .CycleCnt(cnt)
  );

  pc_flag_unit #(.PCW(10), .DW(8), .PROG_LEN(8)) dut8 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
    .Branch(Branch), .Jump(Jump), .Beq(Beq), .Bne(Bne), .Bl(Bl), .Bg(Bg),
    .Cmpfl(Cmpfl), .CmpWr(CmpWr), .CmpA(CmpA), .CmpB(CmpB), .BrTarget(BrTarget),
    .PC(pc8), .Done(done8), .BrTaken(brt8), .FlagEq(feq8), .FlagLt(flt8), .FlagGt(fgt8),
    .CycleCnt(cnt8)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_strobes();
    Branch = 0; Jump = 0; Beq = 0; Bne = 0; Bl = 0; Bg = 0; Cmpfl = 0;
    CmpWr = 0; CmpA = '0; CmpB = '0; BrTarget = '0;
  endtask

  task automatic do_reset();
    clear_strobes();
    Start   = 0;
    Reset_n = 0;
    tick();
    tick();
    Reset_n = 1;
    tick();
  endtask

  task automatic do_start();
    Start = 1;
    tick();
    Start = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pc !== 10'd0) begin bad++; $display("FAIL reset_pc: got %0d want 0", pc); end
    total++; if (done !== 1'b0 || brt !== 1'b0) begin bad++; $display("FAIL reset_done_brt: got %b%b want 00", done, brt); end
    total++; if ({feq, flt, fgt} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {feq, flt, fgt}); end
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    tick();
    tick();
    total++; if (pc !== 10'd0 || cnt !== 16'd0) begin bad++; $display("FAIL idle_hold: got pc=%0d cnt=%0d want 0 0", pc, cnt); end
    do_start();
    total++; if (pc !== 10'd0 || cnt !== 16'd0) begin bad++; $display("FAIL start_edge: got pc=%0d cnt=%0d want 0 0", pc, cnt); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++;
      if (pc !== 10'(i) || cnt !== 16'(i) || {feq, flt, fgt} !== 3'b000) begin
        bad++; $display("FAIL run_seq%0d: got pc=%0d cnt=%0d flags=%b want %0d %0d 000", i, pc, cnt, {feq, flt, fgt}, i, i);
      end
    end
  endtask

  task automatic test_compare_branch();
    do_reset();
    do_start();
    CmpWr = 1; CmpA = 8'd5; CmpB = 8'd9;
    tick();
    clear_strobes();
    total++; if (pc !== 10'd1 || {feq, flt, fgt} !== 3'b010) begin bad++; $display("FAIL cmp_lt: got pc=%0d flags=%b want 1 010", pc, {feq, flt, fgt}); end
    Branch = 1; Cmpfl = 1; Bl = 1; BrTarget = 10'd40;
    tick();
    clear_strobes();
    total++; if (pc !== 10'd40 || brt !== 1'b1) begin bad++; $display("FAIL bl_taken: got pc=%0d brt=%b want 40 1", pc, brt); end
    Branch = 1; Cmpfl = 1; Bg = 1; BrTarget = 10'd60;
    tick();
    clear_strobes();
    total++; if (pc !== 10'd41 || brt !== 1'b0) begin bad++; $display("FAIL bg_not_taken: got pc=%0d brt=%b want 41 0", pc, brt); end
    Branch = 1; Bl = 1; BrTarget = 10'd100;
    tick();
    clear_strobes();
    total++; if (pc !== 10'd42 || brt !== 1'b0) begin bad++; $display("FAIL no_cmpfl: got pc=%0d brt=%b want 42 0", pc, brt); end
    Branch = 1; Jump = 1; BrTarget = 10'd200;
    tick();
    clear_strobes();
    total++; if (pc !== 10'd200 || brt !== 1'b1) begin bad++; $display("FAIL jump: got pc=%0d brt=%b want 200 1", pc, brt); end
  endtask

  task automatic test_hazard();
    do_reset();
    do_start();
    CmpWr = 1; CmpA = 8'd4; CmpB = 8'd4;
    tick();
    total++; if ({feq, flt, fgt} !== 3'b100) begin bad++; $display("FAIL haz_eq_set: got flags=%b want 100", {feq, flt, fgt}); end
    CmpWr = 1; CmpA = 8'd3; CmpB = 8'd3; Branch = 1; Cmpfl = 1; Bne = 1; BrTarget = 10'd50;
    tick();
    clear_strobes();
    total++; if (pc !== 10'd2 || brt !== 1'b0 || feq !== 1'b1) begin bad++; $display("FAIL haz_bne: got pc=%0d brt=%b eq=%b want 2 0 1", pc, brt, feq); end
    CmpWr = 1; CmpA = 8'd7; CmpB = 8'd2; Branch = 1; Cmpfl = 1; Beq = 1; BrTarget = 10'd70;
    tick();
    clear_strobes();
    total++; if (pc !== 10'd70 || brt !== 1'b1 || {feq, flt, fgt} !== 3'b001) begin bad++; $display("FAIL haz_beq: got pc=%0d brt=%b flags=%b want 70 1 001", pc, brt, {feq, flt, fgt}); end
    Branch = 1; Cmpfl = 1; Bne = 1; BrTarget = 10'd90;
    tick();
    clear_strobes();
    total++; if (pc !== 10'd90 || brt !== 1'b1) begin bad++; $display("FAIL haz_bne_new: got pc=%0d brt=%b want 90 1", pc, brt); end
  endtask

  task automatic test_halt_straight();
    do_reset();
    do_start();
    CmpWr = 1; CmpA = 8'd1; CmpB = 8'd2;
    for (int i = 1; i <= 7; i++) begin
      tick();
      clear_strobes();
      total++;
      if (pc8 !== 10'(i) || done8 !== 1'b0) begin
        bad++; $display("FAIL straight_pc%0d: got pc=%0d done=%b want %0d 0", i, pc8, done8, i);
      end
    end
    tick();
    total++; if (pc8 !== 10'd7 || done8 !== 1'b1 || cnt8 !== 16'd8) begin bad++; $display("FAIL halt_edge: got pc=%0d done=%b cnt=%0d want 7 1 8", pc8, done8, cnt8); end
    tick();
    tick();
    total++; if (pc8 !== 10'd7 || done8 !== 1'b1 || cnt8 !== 16'd8 || brt8 !== 1'b0 || flt8 !== 1'b1) begin
      bad++; $display("FAIL halt_frozen: got pc=%0d done=%b cnt=%0d brt=%b lt=%b want 7 1 8 0 1", pc8, done8, cnt8, brt8, flt8);
    end
  endtask

  task automatic test_restart();
    do_start();
    total++; if (pc8 !== 10'd0 || done8 !== 1'b0 || cnt8 !== 16'd0 || {feq8, flt8, fgt8} !== 3'b000) begin
      bad++; $display("FAIL restart: got pc=%0d done=%b cnt=%0d flags=%b want 0 0 0 000", pc8, done8, cnt8, {feq8, flt8, fgt8});
    end
    tick();
    total++; if (pc8 !== 10'd1 || cnt8 !== 16'd1) begin bad++; $display("FAIL restart_run: got pc=%0d cnt=%0d want 1 1", pc8, cnt8); end
  endtask

  task automatic test_halt_jump();
    do_reset();
    do_start();
    tick(); tick(); tick();
    Branch = 1; Jump = 1; BrTarget = 10'd8;
    tick();
    clear_strobes();
    total++; if (pc8 !== 10'd3 || done8 !== 1'b1 || brt8 !== 1'b1 || cnt8 !== 16'd4) begin
      bad++; $display("FAIL jump_halt: got pc=%0d done=%b brt=%b cnt=%0d want 3 1 1 4", pc8, done8, brt8, cnt8);
    end
    tick();
    total++; if (pc8 !== 10'd3 || done8 !== 1'b1 || brt8 !== 1'b0 || cnt8 !== 16'd4) begin
      bad++; $display("FAIL jump_halt_after: got pc=%0d done=%b brt=%b cnt=%0d want 3 1 0 4", pc8, done8, brt8, cnt8);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    do_start();
    CmpWr = 1; CmpA = 8'd9; CmpB = 8'd1;
    tick();
    clear_strobes();
    Branch = 1; Jump = 1; BrTarget = 10'd30;
    tick();
    clear_strobes();
    total++; if (pc !== 10'd30 || brt !== 1'b1 || fgt !== 1'b1) begin bad++; $display("FAIL pre_async: got pc=%0d brt=%b gt=%b want 30 1 1", pc, brt, fgt); end
    #2;
    Reset_n = 0;
    #1;
    total++; if (pc !== 10'd0 || brt !== 1'b0 || cnt !== 16'd0 || {feq, flt, fgt} !== 3'b000 || done !== 1'b0) begin
      bad++; $display("FAIL async_clear: got pc=%0d brt=%b cnt=%0d flags=%b done=%b want 0 0 0 000 0", pc, brt, cnt, {feq, flt, fgt}, done);
    end
    #1;
    Reset_n = 1;
    tick(); tick(); tick();
    total++; if (pc !== 10'd0 || cnt !== 16'd0) begin bad++; $display("FAIL post_async_idle: got pc=%0d cnt=%0d want 0 0", pc, cnt); end
    do_start();
    tick();
    total++; if (pc !== 10'd1 || cnt !== 16'd1) begin bad++; $display("FAIL post_async_run: got pc=%0d cnt=%0d want 1 1", pc, cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    do_start();
    Branch = 1; Jump = 1; BrTarget = 10'd0;
    repeat (65534) tick();
    total++; if (cnt !== 16'hFFFE || pc !== 10'd0 || done !== 1'b0) begin bad++; $display("FAIL sat_pre: got cnt=%h pc=%0d done=%b want fffe 0 0", cnt, pc, done); end
    tick();
    total++; if (cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hit: got cnt=%h want ffff", cnt); end
    repeat (10) tick();
    total++; if (cnt !== 16'hFFFF || brt !== 1'b1) begin bad++; $display("FAIL sat_hold: got cnt=%h brt=%b want ffff 1", cnt, brt); end
    clear_strobes();
  endtask

  initial begin
    clear_strobes();
    Start   = 0;
    Reset_n = 0;
    test_reset();
    test_compare_branch();
    test_hazard();
    test_halt_straight();
    test_restart();
    test_halt_jump();
    test_async_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
